// File: rtl/fifo_wr_ptr_ctrl_if.sv
// Write-side bundle of the CoreFIFO write pointer controller: producer handshake,
// RAM write port, and the Gray pointers exchanged with the read domain.
interface fifo_wr_ptr_ctrl_if #(
    parameter int ADDRWIDTH = 3
);
    logic                 wr_en;
    logic [ADDRWIDTH:0]   rd_ptr_gray_sync;
    logic                 wr_we;
    logic [ADDRWIDTH-1:0] wr_addr;
    logic [ADDRWIDTH:0]   wr_ptr_gray;
    logic                 wr_ack;
    logic                 overflow;
    logic                 full;
    logic                 afull;
    logic [ADDRWIDTH:0]   wr_count;

    // The controller is the slave; the producer/synchronizer environment is the master.
    modport master (
        output wr_en,
        output rd_ptr_gray_sync,
        input  wr_we,
        input  wr_addr,
        input  wr_ptr_gray,
        input  wr_ack,
        input  overflow,
        input  full,
        input  afull,
        input  wr_count
    );

    modport slave (
        input  wr_en,
        input  rd_ptr_gray_sync,
        output wr_we,
        output wr_addr,
        output wr_ptr_gray,
        output wr_ack,
        output overflow,
        output full,
        output afull,
        output wr_count
    );
endinterface

// File: rtl/fifo_wr_ptr_ctrl.sv
// Write-domain pointer/flag controller for the dual-clock CoreFIFO: qualifies writes
// against full, drives the RAM write port and derives full/afull/fill level.
module fifo_wr_ptr_ctrl #(
    parameter int ADDRWIDTH    = 3,
    parameter int AFULL_THRESH = 6
) (
    input  logic                clk,
    input  logic                aresetn,
    fifo_wr_ptr_ctrl_if.slave   bus
);

    localparam logic [ADDRWIDTH:0] AFULL_LVL = (ADDRWIDTH+1)'(AFULL_THRESH);

    logic [ADDRWIDTH:0] wr_ptr_bin;
    logic [ADDRWIDTH:0] wr_ptr_gray_q;
    logic [ADDRWIDTH:0] wr_count_q;
    logic               full_q;
    logic               afull_q;
    logic               wr_ack_q;
    logic               overflow_q;

    logic               accept;
    logic               reject;
    logic [ADDRWIDTH:0] next_bin;
    logic [ADDRWIDTH:0] next_gray;
    logic [ADDRWIDTH:0] rd_bin;
    logic [ADDRWIDTH:0] full_gray;
    logic [ADDRWIDTH:0] count_next;
    logic               full_next;
    logic               afull_next;

    // Gating with aresetn keeps the RAM write enable low for the whole reset interval.
    assign accept     = bus.wr_en & ~full_q & aresetn;
    assign reject     = bus.wr_en & full_q;

    assign next_bin   = wr_ptr_bin + {{ADDRWIDTH{1'b0}}, accept};
    assign next_gray  = next_bin ^ (next_bin >> 1);

    // Each binary bit is the XOR of all Gray bits at and above it.
    always_comb begin
        rd_bin = '0;
        for (int i = 0; i <= ADDRWIDTH; i++) begin
            rd_bin[i] = ^(bus.rd_ptr_gray_sync >> i);
        end
    end

    // Full when the write pointer is exactly one lap ahead of the read pointer.
    assign full_gray  = {~bus.rd_ptr_gray_sync[ADDRWIDTH:ADDRWIDTH-1],
                         bus.rd_ptr_gray_sync[ADDRWIDTH-2:0]};
    assign full_next  = (next_gray == full_gray);
    assign count_next = next_bin - rd_bin;
    assign afull_next = (count_next >= AFULL_LVL);

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_bin    <= '0;
            wr_ptr_gray_q <= '0;
            wr_count_q    <= '0;
            full_q        <= 1'b0;
            afull_q       <= 1'b0;
            wr_ack_q      <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            wr_ptr_bin    <= next_bin;
            wr_ptr_gray_q <= next_gray;
            wr_count_q    <= count_next;
            full_q        <= full_next;
            afull_q       <= afull_next;
            wr_ack_q      <= accept;
            overflow_q    <= reject;
        end
    end

    assign bus.wr_we       = accept;
    assign bus.wr_addr     = wr_ptr_bin[ADDRWIDTH-1:0];
    assign bus.wr_ptr_gray = wr_ptr_gray_q;
    assign bus.wr_count    = wr_count_q;
    assign bus.full        = full_q;
    assign bus.afull       = afull_q;
    assign bus.wr_ack      = wr_ack_q;
    assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_fifo_wr_ptr_ctrl.sv
// Directed self-checking bench for fifo_wr_ptr_ctrl (ADDRWIDTH=3, AFULL_THRESH=6).
module tb_fifo_wr_ptr_ctrl;

    logic clk;
    logic aresetn;
    int   checks;
    int   failures;

    fifo_wr_ptr_ctrl_if #(.ADDRWIDTH(3)) bus ();

    fifo_wr_ptr_ctrl #(
        .ADDRWIDTH    (3),
        .AFULL_THRESH (6)
    ) dut (
        .clk     (clk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] to_gray(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    // Advance to 1 time unit after the next rising edge.
    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.wr_en            = 1'b0;
        bus.rd_ptr_gray_sync = 4'b0000;
        aresetn              = 1'b0;
        #3;
        aresetn              = 1'b1;
        next_edge();
    endtask

    task automatic test_reset();
        aresetn              = 1'b0;
        bus.wr_en            = 1'b1;
        bus.rd_ptr_gray_sync = 4'b0000;
        #1;
        checks++;
        if ({bus.wr_we, bus.wr_addr, bus.wr_ptr_gray, bus.wr_count, bus.full, bus.afull,
             bus.wr_ack, bus.overflow} !== 16'h0000) begin
            failures++;
            $display("[TB] FAIL reset_outputs got we=%b addr=%0d gray=%b cnt=%0d full=%b afull=%b ack=%b ovf=%b exp all 0",
                     bus.wr_we, bus.wr_addr, bus.wr_ptr_gray, bus.wr_count, bus.full, bus.afull,
                     bus.wr_ack, bus.overflow);
        end
        next_edge();
        checks++;
        if (bus.wr_we !== 1'b0 || bus.wr_count !== 4'd0) begin
            failures++;
            $display("[TB] FAIL reset_held got we=%b cnt=%0d exp we=0 cnt=0", bus.wr_we, bus.wr_count);
        end
        aresetn = 1'b1;
        #1;
        checks++;
        if (bus.wr_we !== 1'b1 || bus.wr_addr !== 3'd0) begin
            failures++;
            $display("[TB] FAIL reset_first_write got we=%b addr=%0d exp we=1 addr=0", bus.wr_we, bus.wr_addr);
        end
        next_edge();
        checks++;
        if (bus.wr_ack !== 1'b1 || bus.wr_count !== 4'd1 || bus.wr_addr !== 3'd1) begin
            failures++;
            $display("[TB] FAIL reset_first_ack got ack=%b cnt=%0d addr=%0d exp ack=1 cnt=1 addr=1",
                     bus.wr_ack, bus.wr_count, bus.wr_addr);
        end
        bus.wr_en = 1'b0;
    endtask

    task automatic test_fill_to_full();
        int lvl;
        do_reset();
        for (int c = 1; c <= 10; c++) begin
            bus.wr_en = 1'b1;
            #1;
            checks++;
            if (bus.wr_we !== (c <= 8) || (c <= 8 && bus.wr_addr !== 3'(c - 1))) begin
                failures++;
                $display("[TB] FAIL fill_we_c%0d got we=%b addr=%0d exp we=%b addr=%0d",
                         c, bus.wr_we, bus.wr_addr, (c <= 8), c - 1);
            end
            next_edge();
            lvl = (c < 8) ? c : 8;
            checks++;
            if (bus.wr_count !== 4'(lvl) || bus.afull !== (lvl >= 6) || bus.full !== (c >= 8) ||
                bus.overflow !== (c >= 9) || bus.wr_ack !== (c <= 8)) begin
                failures++;
                $display("[TB] FAIL fill_flags_c%0d got cnt=%0d afull=%b full=%b ovf=%b ack=%b exp cnt=%0d afull=%b full=%b ovf=%b ack=%b",
                         c, bus.wr_count, bus.afull, bus.full, bus.overflow, bus.wr_ack,
                         lvl, (lvl >= 6), (c >= 8), (c >= 9), (c <= 8));
            end
        end
        bus.wr_en = 1'b0;
        checks++;
        if (bus.wr_ptr_gray !== 4'b1100) begin
            failures++;
            $display("[TB] FAIL fill_gray got %b exp 1100", bus.wr_ptr_gray);
        end
    endtask

    task automatic test_release_from_full();
        bus.wr_en            = 1'b0;
        bus.rd_ptr_gray_sync = 4'b0001;
        next_edge();
        checks++;
        if (bus.full !== 1'b0 || bus.wr_count !== 4'd7 || bus.afull !== 1'b1 || bus.overflow !== 1'b0) begin
            failures++;
            $display("[TB] FAIL release_flags got full=%b cnt=%0d afull=%b ovf=%b exp full=0 cnt=7 afull=1 ovf=0",
                     bus.full, bus.wr_count, bus.afull, bus.overflow);
        end
        bus.wr_en = 1'b1;
        #1;
        checks++;
        if (bus.wr_we !== 1'b1 || bus.wr_addr !== 3'd0) begin
            failures++;
            $display("[TB] FAIL release_write got we=%b addr=%0d exp we=1 addr=0", bus.wr_we, bus.wr_addr);
        end
        next_edge();
        bus.wr_en = 1'b0;
        checks++;
        if (bus.full !== 1'b1 || bus.wr_count !== 4'd8 || bus.wr_ptr_gray !== 4'b1101) begin
            failures++;
            $display("[TB] FAIL refull got full=%b cnt=%0d gray=%b exp full=1 cnt=8 gray=1101",
                     bus.full, bus.wr_count, bus.wr_ptr_gray);
        end
    endtask

    task automatic test_gray_wrap();
        logic [3:0] exp_bin;
        logic [3:0] prev_gray;
        do_reset();
        bus.wr_en = 1'b1;
        next_edge();
        next_edge();
        exp_bin   = 4'd2;
        prev_gray = 4'b0011;
        for (int n = 0; n < 32; n++) begin
            bus.rd_ptr_gray_sync = to_gray(exp_bin - 4'd1);
            #1;
            checks++;
            if (bus.wr_we !== 1'b1 || bus.wr_addr !== exp_bin[2:0]) begin
                failures++;
                $display("[TB] FAIL wrap_addr_n%0d got we=%b addr=%0d exp we=1 addr=%0d",
                         n, bus.wr_we, bus.wr_addr, exp_bin[2:0]);
            end
            next_edge();
            exp_bin = exp_bin + 4'd1;
            checks++;
            if (bus.wr_ptr_gray !== to_gray(exp_bin) || $countones(bus.wr_ptr_gray ^ prev_gray) != 1 ||
                bus.wr_count !== 4'd2 || bus.full !== 1'b0) begin
                failures++;
                $display("[TB] FAIL wrap_step_n%0d got gray=%b prev=%b cnt=%0d full=%b exp gray=%b cnt=2 full=0",
                         n, bus.wr_ptr_gray, prev_gray, bus.wr_count, bus.full, to_gray(exp_bin));
            end
            prev_gray = to_gray(exp_bin);
        end
        bus.wr_en = 1'b0;
    endtask

    task automatic test_simultaneous();
        do_reset();
        bus.wr_en = 1'b1;
        for (int n = 0; n < 5; n++) next_edge();
        bus.wr_en = 1'b0;
        checks++;
        if (bus.wr_count !== 4'd5 || bus.afull !== 1'b0) begin
            failures++;
            $display("[TB] FAIL simul_setup got cnt=%0d afull=%b exp cnt=5 afull=0", bus.wr_count, bus.afull);
        end
        bus.wr_en            = 1'b1;
        bus.rd_ptr_gray_sync = 4'b0001;
        next_edge();
        bus.wr_en = 1'b0;
        checks++;
        if (bus.wr_count !== 4'd5 || bus.wr_ack !== 1'b1 || bus.afull !== 1'b0) begin
            failures++;
            $display("[TB] FAIL simul_event got cnt=%0d ack=%b afull=%b exp cnt=5 ack=1 afull=0",
                     bus.wr_count, bus.wr_ack, bus.afull);
        end
    endtask

    task automatic test_reset_mid_op();
        #2;
        aresetn              = 1'b0;
        bus.wr_en            = 1'b1;
        bus.rd_ptr_gray_sync = 4'b0000;
        #1;
        checks++;
        if ({bus.wr_we, bus.wr_addr, bus.wr_ptr_gray, bus.wr_count, bus.full, bus.afull,
             bus.wr_ack, bus.overflow} !== 16'h0000) begin
            failures++;
            $display("[TB] FAIL midreset_outputs got we=%b addr=%0d gray=%b cnt=%0d full=%b afull=%b ack=%b ovf=%b exp all 0",
                     bus.wr_we, bus.wr_addr, bus.wr_ptr_gray, bus.wr_count, bus.full, bus.afull,
                     bus.wr_ack, bus.overflow);
        end
        #2;
        aresetn = 1'b1;
        #1;
        checks++;
        if (bus.wr_we !== 1'b1 || bus.wr_addr !== 3'd0) begin
            failures++;
            $display("[TB] FAIL midreset_write got we=%b addr=%0d exp we=1 addr=0", bus.wr_we, bus.wr_addr);
        end
        next_edge();
        bus.wr_en = 1'b0;
        checks++;
        if (bus.wr_count !== 4'd1 || bus.wr_ack !== 1'b1) begin
            failures++;
            $display("[TB] FAIL midreset_count got cnt=%0d ack=%b exp cnt=1 ack=1", bus.wr_count, bus.wr_ack);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_fill_to_full();
        test_release_from_full();
        test_gray_wrap();
        test_simultaneous();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
